// File: rtl/io_kbd_entry.sv
// PS/2 keyboard hex-entry front end: frame receiver, set-2 decoder,
// entry/commit register and a selectable watch-channel display.
module io_kbd_entry #(
    parameter int DATA_W      = 32,
    parameter int NCH         = 16,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    input  logic [NCH*DATA_W-1:0]   ch_data,
    output logic [DATA_W-1:0]       value,
    output logic                    commit,
    output logic [DATA_W-1:0]       entry,
    output logic [$clog2(NCH)-1:0]  sel,
    output logic [15:0]             led,
    output logic                    err
);

    localparam int SEL_W = $clog2(NCH);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    rx_state_t         state, state_nxt;
    logic [2:0]        kclk_q;
    logic [1:0]        kdat_q;
    logic              fall, bit_in, timeout;
    logic [7:0]        shreg, rx_byte;
    logic [2:0]        bit_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              par_bit, rx_valid, rx_bad;
    logic              brk, ext;
    logic              hex_hit;
    logic [3:0]        hex_dig;

    // kclk_q[2] is the previous synchronized sample, used only for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_q <= '1;
            kdat_q <= '1;
        end else begin
            kclk_q <= {kclk_q[1:0], ps2_clk};
            kdat_q <= {kdat_q[0], ps2_data};
        end
    end

    assign fall    = kclk_q[2] & ~kclk_q[1];
    assign bit_in  = kdat_q[1];
    assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !fall;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall && !bit_in)        state_nxt = DATA;
            DATA:    if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:  if (fall)                   state_nxt = STOP;
            STOP:    if (fall)                   state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
        if (state != IDLE && timeout) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            par_bit  <= 1'b0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_bad   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_bad   <= 1'b0;
            if (state == IDLE || fall || timeout) to_cnt <= '0;
            else                                  to_cnt <= to_cnt + 1'b1;
            case (state)
                IDLE: bit_cnt <= '0;
                DATA: if (fall) begin
                    shreg   <= {bit_in, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY: if (fall) par_bit <= bit_in;
                STOP: if (fall) begin
                    if (bit_in && (^{par_bit, shreg})) begin
                        rx_valid <= 1'b1;
                        rx_byte  <= shreg;
                    end else begin
                        rx_bad <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hex_hit = 1'b1;
        hex_dig = 4'h0;
        case (rx_byte)
            8'h45: hex_dig = 4'h0;  8'h16: hex_dig = 4'h1;
            8'h1E: hex_dig = 4'h2;  8'h26: hex_dig = 4'h3;
            8'h25: hex_dig = 4'h4;  8'h2E: hex_dig = 4'h5;
            8'h36: hex_dig = 4'h6;  8'h3D: hex_dig = 4'h7;
            8'h3E: hex_dig = 4'h8;  8'h46: hex_dig = 4'h9;
            8'h1C: hex_dig = 4'hA;  8'h32: hex_dig = 4'hB;
            8'h21: hex_dig = 4'hC;  8'h23: hex_dig = 4'hD;
            8'h24: hex_dig = 4'hE;  8'h2B: hex_dig = 4'hF;
            default: hex_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry  <= '0;
            value  <= '0;
            sel    <= '0;
            brk    <= 1'b0;
            ext    <= 1'b0;
            commit <= 1'b0;
            err    <= 1'b0;
        end else begin
            commit <= 1'b0;
            err    <= rx_bad;
            if (rx_bad) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (brk) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else if (ext) begin
                    ext <= 1'b0;
                    if (rx_byte == 8'h75)
                        sel <= (sel == SEL_W'(NCH - 1)) ? '0 : sel + SEL_W'(1);
                    else if (rx_byte == 8'h72)
                        sel <= (sel == '0) ? SEL_W'(NCH - 1) : sel - SEL_W'(1);
                end else if (hex_hit) begin
                    entry <= {entry[DATA_W-5:0], hex_dig};
                end else begin
                    case (rx_byte)
                        8'h66: entry <= entry >> 4;
                        8'h76: entry <= '0;
                        8'h5A: begin
                            value  <= entry;
                            entry  <= '0;
                            commit <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb led = ch_data[int'(sel)*DATA_W +: 16];

endmodule

// File: tb/tb_io_kbd_entry.sv
// Directed bench for io_kbd_entry: drives PS/2 frames bit by bit and checks
// entry/value/sel/led plus commit/err pulse timing.
module tb_io_kbd_entry;

    localparam int DATA_W = 32;
    localparam int NCH    = 16;
    localparam int TO     = 300;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  ps2_clk = 1'b1;
    logic                  ps2_data = 1'b1;
    logic [NCH*DATA_W-1:0] ch_data;
    logic [DATA_W-1:0]     value, entry;
    logic                  commit, err;
    logic [3:0]            sel;
    logic [15:0]           led;

    int unsigned n_chk = 0, n_pass = 0, err_cnt = 0;
    logic [2:0] cpat, epat;

    io_kbd_entry #(.DATA_W(DATA_W), .NCH(NCH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ch_data(ch_data), .value(value), .commit(commit), .entry(entry),
        .sel(sel), .led(led), .err(err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (err) err_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(8);
        ps2_clk = 1'b0;
        wait_cyc(8);
        ps2_clk = 1'b1;
    endtask

    // Samples commit/err on the 3rd..5th cycle after the stop-bit falling edge
    task automatic send_frame(input logic [7:0] code, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(~^code ^ flip);
        ps2_data = 1'b1;
        wait_cyc(8);
        ps2_clk = 1'b0;
        wait_cyc(3); cpat[2] = commit; epat[2] = err;
        wait_cyc(1); cpat[1] = commit; epat[1] = err;
        wait_cyc(1); cpat[0] = commit; epat[0] = err;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(16);
    endtask

    initial begin
        for (int k = 0; k < NCH; k++)
            ch_data[k*DATA_W +: DATA_W] = {16'hDEAD ^ 16'(k), 16'h1000 + 16'(k) * 16'h0101};

        wait_cyc(3);
        check("rst_value", value, 0);
        check("rst_entry", entry, 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_pulses", {30'd0, commit, err}, 0);
        rst = 1'b0;
        wait_cyc(4);

        send_frame(8'h16, 0); check("k1", entry, 32'h1);
        send_frame(8'h1E, 0); check("k12", entry, 32'h12);
        send_frame(8'h1C, 0); check("k12A", entry, 32'h12A);
        send_frame(8'h5A, 0);
        check("enter_entry", entry, 0);
        check("enter_value", value, 32'h0000012A);
        check("commit_timing", 32'(cpat), 32'b010);

        send_frame(8'h16, 0); send_frame(8'h1E, 0); send_frame(8'h26, 0);
        send_frame(8'h25, 0); send_frame(8'h2E, 0); send_frame(8'h36, 0);
        send_frame(8'h3D, 0); send_frame(8'h3E, 0); send_frame(8'h46, 0);
        check("wrap9", entry, 32'h23456789);
        send_frame(8'h66, 0); check("bksp", entry, 32'h02345678);
        send_frame(8'h76, 0); check("esc", entry, 0);

        send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        check("break_skip", entry, 32'hA);

        send_frame(8'hE0, 0); send_frame(8'h72, 0);
        check("sel_down_wrap", 32'(sel), 15);
        check("led15", 32'(led), 32'h1F0F);
        send_frame(8'hE0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'h75, 0);
        check("sel_up2", 32'(sel), 1);
        check("led1", 32'(led), 32'h1101);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        check("ext_break", 32'(sel), 1);
        send_frame(8'hE0, 0); send_frame(8'h5A, 0);
        check("ext_enter_commit", 32'(cpat), 0);
        check("ext_enter_value", value, 32'h12A);
        check("ext_enter_entry", entry, 32'hA);

        send_frame(8'h16, 1);
        check("bad_par_err", 32'(epat), 32'b010);
        check("bad_par_entry", entry, 32'hA);
        send_frame(8'h16, 0); check("good_after_bad", entry, 32'hA1);

        begin
            int unsigned e0;
            e0 = err_cnt;
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(1'b1);
            wait_cyc(TO + 20);
            send_frame(8'h45, 0);
            check("timeout_entry", entry, 32'hA10);
            check("timeout_no_err", err_cnt, e0);
        end

        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("midrst_entry", entry, 0);
        check("midrst_value", value, 0);
        check("midrst_sel", 32'(sel), 0);
        check("midrst_pulses", {30'd0, commit, err}, 0);
        wait_cyc(20);
        send_frame(8'h26, 0); check("post_rst_frame", entry, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
